// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the scoreboarded GPR file.
// Imported by the interface, the scoreboard and the top level.
package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bundle of the GPR file.
// The master side is decode plus writeback; the slave side is the register file.
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NREAD = 2
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [NREAD*AW-1:0]   raddr;
    logic [NREAD*XLEN-1:0] rdata;
    logic [NREAD-1:0]      rbusy;
    logic                  iss_valid;
    logic [AW-1:0]         iss_rd;
    logic                  iss_stall;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [XLEN-1:0]       wdata;
    logic [CW-1:0]         busy_cnt;

    modport master (
        output raddr, iss_valid, iss_rd, we, waddr, wdata,
        input  rdata, rbusy, iss_stall, busy_cnt
    );

    modport slave (
        input  raddr, iss_valid, iss_rd, we, waddr, wdata,
        output rdata, rbusy, iss_stall, busy_cnt
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits with a running popcount.
// Issue marks a destination busy, writeback clears it; issue wins on a collision.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    output logic [DEPTH-1:0] busy,
    output logic             iss_stall,
    output logic [CW-1:0]    busy_cnt
);

    logic [DEPTH-1:0] busy_q;
    logic [CW-1:0]    cnt_q;
    logic             rd_zero;
    logic             byp;
    logic             set;
    logic             set_new;
    logic             clr_old;

    assign rd_zero   = (ZERO_REG != 0) && (iss_rd == '0);
    assign byp       = we && (waddr == iss_rd);
    assign iss_stall = iss_valid & busy_q[iss_rd] & ~byp & ~rd_zero;
    assign set       = iss_valid & ~iss_stall & ~rd_zero;

    // A same-register set+clear leaves the bit set, so neither side moves the count.
    assign set_new = set & ~busy_q[iss_rd];
    assign clr_old = we & busy_q[waddr] & ~(set & (iss_rd == waddr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (set && iss_rd == AW'(i))
                    busy_q[i] <= 1'b1;
                else if (we && waddr == AW'(i))
                    busy_q[i] <= 1'b0;
            end
            cnt_q <= cnt_q + CW'(set_new) - CW'(clr_old);
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port GPR file with write-first bypass and busy scoreboard.
// Reads are combinational; writes and scoreboard updates land on the rising edge.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input logic          clk,
    input logic          rst_n,
    reg_file_sb_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             wr_zero;

    assign wr_zero = (ZERO_REG != 0) && (bus.waddr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (bus.we && !wr_zero) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    reg_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .we        (bus.we),
        .waddr     (bus.waddr),
        .busy      (busy),
        .iss_stall (bus.iss_stall),
        .busy_cnt  (bus.busy_cnt)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        logic          rz;

        assign ra  = bus.raddr[i*AW +: AW];
        assign hit = bus.we && (bus.waddr == ra);
        assign rz  = (ZERO_REG != 0) && (ra == '0);

        assign bus.rdata[i*XLEN +: XLEN] = rz  ? '0 :
                                           hit ? bus.wdata : mem[ra];
        assign bus.rbusy[i] = busy[ra] & ~hit & ~rz;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus random traffic on two configurations,
// checked against an array-based model of registers and busy set.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_sb_if #(.XLEN(32), .DEPTH(32), .NREAD(2)) ia ();
    reg_file_sb_if #(.XLEN(64), .DEPTH(16), .NREAD(4)) ib ();

    reg_file_sb #(.XLEN(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia.slave)
    );

    reg_file_sb #(.XLEN(64), .DEPTH(16), .NREAD(4), .ZERO_REG(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib.slave)
    );

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    logic [63:0] mm [2][32];
    bit          mb [2][32];

    int          r [4];
    bit          iv;
    int          ird;
    bit          we_s;
    int          wa;
    logic [63:0] wd;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        ntot++;
        assert (o === e) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 32; k++) begin
                mm[s][k] = '0;
                mb[s][k] = 1'b0;
            end
    endtask

    function automatic int model_cnt(input int s);
        int c = 0;
        for (int k = 0; k < 32; k++)
            if (mb[s][k]) c++;
        return c;
    endfunction

    task automatic idle();
        ia.iss_valid = 1'b0;
        ia.we        = 1'b0;
        ib.iss_valid = 1'b0;
        ib.we        = 1'b0;
    endtask

    task automatic read_checks(input int s, input string tag);
        int np = (s != 0) ? 4 : 2;
        logic [63:0] wdv = (s != 0) ? wd : {32'h0, wd[31:0]};
        for (int p = 0; p < np; p++) begin
            bit          hit;
            logic [63:0] ed;
            logic [63:0] od;
            bit          eb;
            logic        ob;
            hit = we_s && (wa == r[p]);
            ed  = (r[p] == 0) ? 64'h0 : hit ? wdv : mm[s][r[p]];
            eb  = (r[p] != 0) && mb[s][r[p]] && !hit;
            od  = (s != 0) ? ib.rdata[p*64 +: 64] : {32'h0, ia.rdata[p*32 +: 32]};
            ob  = (s != 0) ? ib.rbusy[p] : ia.rbusy[p];
            chk($sformatf("%s_rdata%0d", tag, p), od, ed);
            chk($sformatf("%s_rbusy%0d", tag, p), {63'h0, ob}, {63'h0, eb});
        end
    endtask

    task automatic cyc(input int s, input string tag);
        logic [63:0] wdv = (s != 0) ? wd : {32'h0, wd[31:0]};
        bit          stall_e;
        bit          set_e;
        logic        so;
        logic [63:0] co;
        idle();
        if (s == 0) begin
            ia.raddr     = {5'(r[1]), 5'(r[0])};
            ia.iss_valid = iv;
            ia.iss_rd    = 5'(ird);
            ia.we        = we_s;
            ia.waddr     = 5'(wa);
            ia.wdata     = wd[31:0];
        end else begin
            ib.raddr     = {4'(r[3]), 4'(r[2]), 4'(r[1]), 4'(r[0])};
            ib.iss_valid = iv;
            ib.iss_rd    = 4'(ird);
            ib.we        = we_s;
            ib.waddr     = 4'(wa);
            ib.wdata     = wd;
        end
        #1;
        read_checks(s, tag);
        stall_e = iv && (ird != 0) && mb[s][ird] && !(we_s && wa == ird);
        so = (s != 0) ? ib.iss_stall : ia.iss_stall;
        chk({tag, "_stall"}, {63'h0, so}, {63'h0, stall_e});
        @(posedge clk);
        if (we_s && wa != 0) mm[s][wa] = wdv;
        set_e = iv && !stall_e && (ird != 0);
        if (we_s) mb[s][wa] = 1'b0;
        if (set_e) mb[s][ird] = 1'b1;
        #1;
        co = (s != 0) ? 64'(ib.busy_cnt) : 64'(ia.busy_cnt);
        chk({tag, "_cnt"}, co, 64'(model_cnt(s)));
    endtask

    task automatic set_in(input int r0, input int r1, input bit v, input int rd,
                          input bit w, input int a, input logic [63:0] d);
        r[0] = r0; r[1] = r1; r[2] = 0; r[3] = 0;
        iv = v; ird = rd; we_s = w; wa = a; wd = d;
    endtask

    task automatic rand_in(input int s, input int amax);
        for (int p = 0; p < 4; p++) r[p] = $urandom_range(0, amax);
        iv   = 1'($urandom_range(0, 1));
        ird  = $urandom_range(0, amax);
        we_s = 1'($urandom_range(0, 1));
        wa   = $urandom_range(0, amax);
        wd   = {$urandom, $urandom};
        if (s == 0) r[2] = 0;
        if (s == 0) r[3] = 0;
    endtask

    task automatic reset_check();
        logic [63:0] d;
        idle();
        we_s = 1'b0;
        iv   = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) begin
            d = {32'h0, ia.rdata[p*32 +: 32]};
            chk($sformatf("rst_a_rdata%0d", p), d, 64'h0);
        end
        for (int p = 0; p < 4; p++) begin
            d = ib.rdata[p*64 +: 64];
            chk($sformatf("rst_b_rdata%0d", p), d, 64'h0);
        end
        chk("rst_a_rbusy", 64'(ia.rbusy), 64'h0);
        chk("rst_b_rbusy", 64'(ib.rbusy), 64'h0);
        chk("rst_a_cnt", 64'(ia.busy_cnt), 64'h0);
        chk("rst_b_cnt", 64'(ib.busy_cnt), 64'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_clear();
        ia.raddr = '0; ia.iss_rd = '0; ia.waddr = '0; ia.wdata = '0;
        ib.raddr = '0; ib.iss_rd = '0; ib.waddr = '0; ib.wdata = '0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        set_in(0, 1, 0, 0, 0, 0, 64'h0);
        cyc(0, "reset_state");

        set_in(5, 0, 0, 0, 1, 5, 64'hDEAD_BEEF);
        cyc(0, "wr_bypass");
        set_in(5, 0, 0, 0, 0, 0, 64'h0);
        cyc(0, "wr_hold");

        set_in(0, 5, 1, 0, 1, 0, 64'hFFFF_FFFF);
        cyc(0, "x0_write");
        set_in(0, 0, 0, 0, 0, 0, 64'h0);
        cyc(0, "x0_after");

        set_in(7, 0, 1, 7, 0, 0, 64'h0);
        cyc(0, "iss7");
        set_in(7, 0, 1, 7, 0, 0, 64'h0);
        cyc(0, "iss7_waw");
        set_in(7, 0, 0, 0, 1, 7, 64'h1234_5678);
        cyc(0, "wb7");
        set_in(7, 0, 1, 7, 1, 7, 64'h0000_0077);
        cyc(0, "iss7_wb7");
        set_in(7, 0, 0, 0, 1, 7, 64'h0000_0777);
        cyc(0, "wb7_clear");

        set_in(3, 9, 1, 3, 0, 0, 64'h0);
        cyc(0, "iss3");
        set_in(3, 9, 1, 9, 0, 0, 64'h0);
        cyc(0, "iss9");
        set_in(3, 9, 1, 3, 1, 3, 64'hAAAA_0003);
        cyc(0, "iss3_wb3");
        set_in(4, 9, 1, 4, 1, 9, 64'hBBBB_0009);
        cyc(0, "iss4_wb9");
        set_in(4, 9, 0, 0, 0, 0, 64'h0);
        cyc(0, "busy_set");

        for (int n = 0; n < 300; n++) begin
            rand_in(0, 7);
            cyc(0, "rand_a");
        end
        for (int n = 0; n < 200; n++) begin
            rand_in(0, 31);
            cyc(0, "rand_a_wide");
        end

        reset_check();
        set_in(3, 4, 0, 0, 0, 0, 64'h0);
        cyc(0, "post_rst");

        for (int k = 0; k < 16; k++) begin
            set_in($urandom_range(0, 15), $urandom_range(0, 15), 0, 0, 1, k,
                   {$urandom, $urandom});
            r[2] = $urandom_range(0, 15);
            r[3] = k;
            cyc(1, "b_fill");
        end
        for (int k = 0; k < 16; k += 4) begin
            set_in(k, k + 1, 0, 0, 0, 0, 64'h0);
            r[2] = k + 2;
            r[3] = k + 3;
            cyc(1, "b_read");
        end
        for (int k = 1; k < 16; k++) begin
            set_in(k, 0, 1, k, 0, 0, 64'h0);
            cyc(1, "b_busy");
        end
        set_in(5, 15, 1, 5, 0, 0, 64'h0);
        cyc(1, "b_full_stall");
        set_in(0, 1, 1, 0, 0, 0, 64'h0);
        cyc(1, "b_full_x0");
        for (int n = 0; n < 300; n++) begin
            rand_in(1, 15);
            cyc(1, "rand_b");
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #2000000;
        ntot++;
        nfail++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
